decode_issue_sb: RTL

- Parametrised successor to the single-cycle decode stage: decodes WISC 16-bit instructions, reads an internal register file, and resolves B/BR branches in decode.
- Unlike its predecessor, it tracks in-flight register and flag writes in a scoreboard and stalls on hazards, so downstream forwarding is optional.
- Valid/ready handshakes toward IF and EX; registered outputs with one-cycle latency.
- Sits between the IF/ID pipe register and EX; WB writes back into it.

---
 rtl/decode_issue_sb.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/decode_issue_sb.sv
// Decode/issue stage for WISC 16-bit instructions: register file, in-flight
// write scoreboard with hazard stalls, decode-time branch resolution.
module decode_issue_sb #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned NREGS  = 16,
   parameter int unsigned CNT_W  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_valid,
   output logic              if_ready,
   input  logic [15:0]       if_inst,
   input  logic [ADDR_W-1:0] if_pc_next,
   input  logic [2:0]        flags,
   input  logic              flag_wb,
   input  logic              wb_en,
   input  logic [3:0]        wb_rd,
   input  logic [DATA_W-1:0] wb_data,
   output logic              ex_valid,
   input  logic              ex_ready,
   output logic [3:0]        ex_opcode,
   output logic [3:0]        ex_rd,
   output logic [DATA_W-1:0] ex_a,
   output logic [DATA_W-1:0] ex_b,
   output logic [DATA_W-1:0] ex_imm,
   output logic              ex_regwrite,
   output logic              ex_setflags,
   output logic              br_valid,
   output logic              br_taken,
   output logic [ADDR_W-1:0] br_target,
   output logic              halted
);

   localparam int unsigned MW = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] regs_d [NREGS];
   logic [CNT_W-1:0]  cnt_q [NREGS];
   logic [CNT_W-1:0]  cnt_d [NREGS];
   logic [CNT_W-1:0]  cnt_eff [NREGS];
   logic [NREGS-1:0]  dec;
   logic [CNT_W-1:0]  fcnt_q, fcnt_d, fcnt_eff;
   logic              fdec;

   logic              ex_valid_q, ex_valid_d;
   logic [3:0]        ex_opcode_q, ex_opcode_d, ex_rd_q, ex_rd_d;
   logic [DATA_W-1:0] ex_a_q, ex_a_d, ex_b_q, ex_b_d, ex_imm_q, ex_imm_d;
   logic              ex_regwrite_q, ex_regwrite_d, ex_setflags_q, ex_setflags_d;
   logic              br_valid_q, br_valid_d, br_taken_q, br_taken_d;
   logic [ADDR_W-1:0] br_target_q, br_target_d;
   logic              halted_q, halted_d;

   logic [3:0]        op, rd, rs, rt;
   logic [2:0]        cc;
   logic              is_nop, is_branch, is_br;
   logic              rd_rs, rd_rt, rd_rdsrc, writer, setflag, need_flags;
   logic [DATA_W-1:0] rs_val, rt_val, rd_val, a_val, b_val, imm_val;
   logic [MW-1:0]     pc_ext, rs_ext;
   logic [ADDR_W-1:0] off, tgt;
   logic              cond, hazard, out_free, accept, load, br_acc;

   assign op = if_inst[15:12];
   assign rd = if_inst[11:8];
   assign rs = if_inst[7:4];
   assign rt = if_inst[3:0];
   assign cc = if_inst[11:9];

   // Instruction class decode; NOP is masked out of every source/destination
   always_comb begin
      is_nop     = (if_inst == 16'h0000);
      is_br      = (op == 4'hD);
      is_branch  = (op == 4'hC) || is_br;
      rd_rs      = !is_nop && ((op <= 4'h9) || is_br);
      rd_rt      = !is_nop && ((op <= 4'h3) || (op == 4'h7));
      rd_rdsrc   = (op == 4'h9) || (op == 4'hA) || (op == 4'hB);
      writer     = !is_nop && ((op <= 4'h8) || (op == 4'hA) || (op == 4'hB) || (op == 4'hE));
      setflag    = !is_nop && ((op <= 4'h2) || ((op >= 4'h4) && (op <= 4'h6)));
      need_flags = is_branch && (cc != 3'b111);
   end

   // Register reads with write-before-read bypass from WB
   assign rs_val = (rs == 4'd0) ? '0 : (wb_en && (wb_rd == rs)) ? wb_data : regs_q[rs];
   assign rt_val = (rt == 4'd0) ? '0 : (wb_en && (wb_rd == rt)) ? wb_data : regs_q[rt];
   assign rd_val = (rd == 4'd0) ? '0 : (wb_en && (wb_rd == rd)) ? wb_data : regs_q[rd];
   assign pc_ext = MW'(if_pc_next);
   assign rs_ext = MW'(rs_val);

   // Operand and immediate selection per opcode
   always_comb begin
      a_val   = '0;
      b_val   = '0;
      imm_val = '0;
      if (op <= 4'h9) a_val = rs_val;
      if ((op == 4'hA) || (op == 4'hB)) a_val = rd_val;
      if ((op <= 4'h3) || (op == 4'h7)) b_val = rt_val;
      if (op == 4'h9) b_val = rd_val;
      case (op)
         4'h4, 4'h5, 4'h6: imm_val = DATA_W'(if_inst[3:0]);
         4'h8, 4'h9:       imm_val = {{(DATA_W-4){if_inst[3]}}, if_inst[3:0]};
         4'hA, 4'hB:       imm_val = DATA_W'(if_inst[7:0]);
         4'hE:             imm_val = pc_ext[DATA_W-1:0];
         default:          imm_val = '0;
      endcase
   end

   // Branch condition on {Z,V,N} and target
   always_comb begin
      case (cc)
         3'b000:  cond = !flags[2];
         3'b001:  cond = flags[2];
         3'b010:  cond = !flags[2] && !flags[0];
         3'b011:  cond = flags[0];
         3'b100:  cond = flags[2] || (!flags[2] && !flags[0]);
         3'b101:  cond = flags[0] || flags[2];
         3'b110:  cond = flags[1];
         default: cond = 1'b1;
      endcase
      off = {{(ADDR_W-9){if_inst[8]}}, if_inst[8:0]};
      tgt = is_br ? rs_ext[ADDR_W-1:0] : (if_pc_next + (off << 1));
   end

   // Counts as they will look after this cycle's write-back decrements
   always_comb begin
      for (int r = 0; r < NREGS; r++) begin
         dec[r]     = wb_en && (wb_rd == 4'(r)) && (r != 0) && (cnt_q[r] != '0);
         cnt_eff[r] = cnt_q[r] - CNT_W'(dec[r]);
      end
      fdec     = flag_wb && (fcnt_q != '0);
      fcnt_eff = fcnt_q - CNT_W'(fdec);
   end

   // Hazard detection and handshake
   always_comb begin
      hazard = (rd_rs && (rs != 4'd0) && (cnt_eff[rs] != '0)) ||
               (rd_rt && (rt != 4'd0) && (cnt_eff[rt] != '0)) ||
               (rd_rdsrc && (rd != 4'd0) && (cnt_eff[rd] != '0)) ||
               (writer && (cnt_eff[rd] == CNT_MAX)) ||
               (setflag && (fcnt_eff == CNT_MAX)) ||
               (need_flags && (fcnt_eff != '0));
      out_free = !ex_valid_q || ex_ready;
      if_ready = !halted_q && !hazard && (out_free || is_nop || is_branch);
      accept   = if_valid && if_ready;
      load     = accept && !is_nop && !is_branch;
      br_acc   = accept && is_branch;
   end

   // Next-state for outputs, register file and scoreboard
   always_comb begin
      ex_valid_d    = ex_valid_q;
      ex_opcode_d   = ex_opcode_q;
      ex_rd_d       = ex_rd_q;
      ex_a_d        = ex_a_q;
      ex_b_d        = ex_b_q;
      ex_imm_d      = ex_imm_q;
      ex_regwrite_d = ex_regwrite_q;
      ex_setflags_d = ex_setflags_q;
      br_valid_d    = 1'b0;
      br_taken_d    = br_taken_q;
      br_target_d   = br_target_q;
      halted_d      = halted_q || (load && (op == 4'hF));
      fcnt_d        = fcnt_q;
      if (ex_valid_q && ex_ready) ex_valid_d = 1'b0;
      if (load) begin
         ex_valid_d    = 1'b1;
         ex_opcode_d   = op;
         ex_rd_d       = rd;
         ex_a_d        = a_val;
         ex_b_d        = b_val;
         ex_imm_d      = imm_val;
         ex_regwrite_d = writer;
         ex_setflags_d = setflag;
      end
      if (br_acc) begin
         br_valid_d  = 1'b1;
         br_taken_d  = cond;
         br_target_d = tgt;
      end
      for (int r = 0; r < NREGS; r++) begin
         regs_d[r] = regs_q[r];
         if (wb_en && (wb_rd == 4'(r)) && (r != 0)) regs_d[r] = wb_data;
         cnt_d[r] = cnt_q[r];
         case ({load && writer && (rd == 4'(r)) && (r != 0), dec[r]})
            2'b10:   cnt_d[r] = cnt_q[r] + CNT_W'(1);
            2'b01:   cnt_d[r] = cnt_q[r] - CNT_W'(1);
            default: cnt_d[r] = cnt_q[r];
         endcase
      end
      case ({load && setflag, fdec})
         2'b10:   fcnt_d = fcnt_q + CNT_W'(1);
         2'b01:   fcnt_d = fcnt_q - CNT_W'(1);
         default: fcnt_d = fcnt_q;
      endcase
   end

   // State registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid_q    <= 1'b0;
         ex_opcode_q   <= '0;
         ex_rd_q       <= '0;
         ex_a_q        <= '0;
         ex_b_q        <= '0;
         ex_imm_q      <= '0;
         ex_regwrite_q <= 1'b0;
         ex_setflags_q <= 1'b0;
         br_valid_q    <= 1'b0;
         br_taken_q    <= 1'b0;
         br_target_q   <= '0;
         halted_q      <= 1'b0;
         fcnt_q        <= '0;
         for (int r = 0; r < NREGS; r++) begin
            regs_q[r] <= '0;
            cnt_q[r]  <= '0;
         end
      end else begin
         ex_valid_q    <= ex_valid_d;
         ex_opcode_q   <= ex_opcode_d;
         ex_rd_q       <= ex_rd_d;
         ex_a_q        <= ex_a_d;
         ex_b_q        <= ex_b_d;
         ex_imm_q      <= ex_imm_d;
         ex_regwrite_q <= ex_regwrite_d;
         ex_setflags_q <= ex_setflags_d;
         br_valid_q    <= br_valid_d;
         br_taken_q    <= br_taken_d;
         br_target_q   <= br_target_d;
         halted_q      <= halted_d;
         fcnt_q        <= fcnt_d;
         for (int r = 0; r < NREGS; r++) begin
            regs_q[r] <= regs_d[r];
            cnt_q[r]  <= cnt_d[r];
         end
      end
   end

   assign ex_valid    = ex_valid_q;
   assign ex_opcode   = ex_opcode_q;
   assign ex_rd       = ex_rd_q;
   assign ex_a        = ex_a_q;
   assign ex_b        = ex_b_q;
   assign ex_imm      = ex_imm_q;
   assign ex_regwrite = ex_regwrite_q;
   assign ex_setflags = ex_setflags_q;
   assign br_valid    = br_valid_q;
   assign br_taken    = br_taken_q;
   assign br_target   = br_target_q;
   assign halted      = halted_q;

endmodule
